// File: rtl/ahb_apb_bridge_p.sv
// AHB-Lite to APB bridge with one-hot slot decode from an address field,
// optional ACCESS-phase timeout, and a two-cycle AHB error response.
//
// state  | meaning
// IDLE   | no transfer, AHB side ready
// SETUP  | APB setup phase, PSEL high, PENABLE low, write data captured
// ACCESS | APB access phase, PENABLE high, waiting on PREADY
// ERR1   | first error cycle, HRESP=1, HREADYOUT=0
// ERR2   | second error cycle, HRESP=1, HREADYOUT=1, may accept next
module ahb_apb_bridge_p #(
    parameter int NSLOTS   = 16,
    parameter int SLOT_LSB = 24,
    parameter int TIMEOUT  = 0
) (
    input  logic              HCLK,
    input  logic              HRESETN,
    input  logic              HSEL,
    input  logic              HWRITE,
    input  logic              HREADYIN,
    input  logic [31:0]       HADDR,
    input  logic [31:0]       HWDATA,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [3:0]        HPROT,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [NSLOTS-1:0] PSEL,
    output logic [31:0]       PADDR,
    output logic              PWRITE,
    output logic              PENABLE,
    output logic [31:0]       PWDATA,
    output logic [3:0]        PSTRB,
    output logic [2:0]        PPROT,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [3:0]  slot_q, slot_d;
    logic [3:0]  pstrb_q, pstrb_d;
    logic [2:0]  pprot_q, pprot_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [31:0] cnt_q, cnt_d;

    logic        access_done;
    logic        accept;
    logic        bad_req;
    logic [3:0]  slot_new;
    logic [3:0]  strb_new;
    state_t      accept_target;

    // HTRANS[0] (SEQ vs NONSEQ) and the upper HPROT bits carry no meaning on APB.
    logic unused_ok;
    assign unused_ok = &{1'b0, HTRANS[0], HPROT[3:2]};

    // Request decode, next-state and capture of the address-phase controls.
    always_comb begin
        access_done   = PREADY & ~PSLVERR;
        accept        = HSEL & HREADYIN & HTRANS[1] &
                        ((state_q == ST_IDLE) || (state_q == ST_ERR2) ||
                         ((state_q == ST_ACCESS) && access_done));
        slot_new      = HADDR[SLOT_LSB+3:SLOT_LSB];
        bad_req       = ({1'b0, slot_new} >= 5'(NSLOTS)) || (HSIZE > 3'd2);
        accept_target = bad_req ? ST_ERR1 : ST_SETUP;

        strb_new = 4'b0000;
        if (HWRITE) begin
            case (HSIZE)
                3'd0:    strb_new = 4'b0001 << HADDR[1:0];
                3'd1:    strb_new = HADDR[1] ? 4'b1100 : 4'b0011;
                default: strb_new = 4'b1111;
            endcase
        end

        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        slot_d   = slot_q;
        pstrb_d  = pstrb_q;
        pprot_d  = pprot_q;
        pwdata_d = pwdata_q;
        cnt_d    = cnt_q;

        if (accept) begin
            addr_d  = HADDR;
            write_d = HWRITE;
            slot_d  = slot_new;
            pstrb_d = strb_new;
            pprot_d = {~HPROT[0], 1'b1, HPROT[1]};
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = accept_target;
            end
            ST_SETUP: begin
                pwdata_d = HWDATA;
                cnt_d    = '0;
                state_d  = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR)     state_d = ST_ERR1;
                    else if (accept) state_d = accept_target;
                    else             state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    if ((TIMEOUT > 0) && (cnt_q == 32'(TIMEOUT - 1))) state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                state_d = accept ? accept_target : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered state and APB request fields, synchronous active-low reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            slot_q   <= '0;
            pstrb_q  <= '0;
            pprot_q  <= '0;
            pwdata_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            slot_q   <= slot_d;
            pstrb_q  <= pstrb_d;
            pprot_q  <= pprot_d;
            pwdata_q <= pwdata_d;
            cnt_q    <= cnt_d;
        end
    end

    // State-decoded handshake outputs; HREADYOUT follows PREADY during ACCESS.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        PENABLE   = 1'b0;
        PSEL      = '0;
        case (state_q)
            ST_SETUP:  HREADYOUT = 1'b0;
            ST_ACCESS: begin
                HREADYOUT = access_done;
                PENABLE   = 1'b1;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2:   HRESP = 1'b1;
            default:   HREADYOUT = 1'b1;
        endcase
        for (int i = 0; i < NSLOTS; i++) begin
            PSEL[i] = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) && (slot_q == 4'(i));
        end
    end

    assign HRDATA = PRDATA;
    assign PADDR  = addr_q;
    assign PWRITE = write_q;
    assign PWDATA = pwdata_q;
    assign PSTRB  = pstrb_q;
    assign PPROT  = pprot_q;

endmodule

// File: tb/tb_ahb_apb_bridge_p.sv
// Directed bench for ahb_apb_bridge_p with four slots and an 8-cycle timeout.
module tb_ahb_apb_bridge_p;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel, hwrite, hreadyin;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hrdata;
    logic        hreadyout, hresp;
    logic [3:0]  psel;
    logic [31:0] paddr;
    logic        pwrite, penable;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready, pslverr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 hclk = ~hclk;

    ahb_apb_bridge_p #(.NSLOTS(4), .SLOT_LSB(24), .TIMEOUT(8)) dut (
        .HCLK(hclk), .HRESETN(hresetn), .HSEL(hsel), .HWRITE(hwrite),
        .HREADYIN(hreadyin), .HADDR(haddr), .HWDATA(hwdata), .HTRANS(htrans),
        .HSIZE(hsize), .HPROT(hprot), .HRDATA(hrdata), .HREADYOUT(hreadyout),
        .HRESP(hresp), .PSEL(psel), .PADDR(paddr), .PWRITE(pwrite),
        .PENABLE(penable), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic mid();
        @(negedge hclk);
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = 32'h0;
        hsize  = 3'd0;
        hprot  = 4'h0;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz,
                              input logic [3:0] pr);
        hsel     = 1'b1;
        htrans   = 2'b10;
        hreadyin = 1'b1;
        haddr    = a;
        hwrite   = w;
        hsize    = sz;
        hprot    = pr;
    endtask

    initial begin
        hresetn  = 1'b0;
        hreadyin = 1'b1;
        hwdata   = 32'h0;
        prdata   = 32'h0;
        pready   = 1'b0;
        pslverr  = 1'b0;
        bus_idle();
        step(); step();
        mid();
        chk("rst_hreadyout", hreadyout, 1);
        chk("rst_hresp", hresp, 0);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pstrb", pstrb, 0);
        chk("rst_pprot", pprot, 0);
        chk("rst_pwrite", pwrite, 0);

        // BUSY transfer is ignored
        step(); hresetn = 1'b1;
        hsel = 1'b1; htrans = 2'b01; haddr = 32'h0100_0000;
        mid();
        chk("busy_hreadyout", hreadyout, 1);
        chk("busy_hresp", hresp, 0);
        step(); bus_idle();
        mid();
        chk("busy_psel", psel, 0);
        chk("busy_hreadyout2", hreadyout, 1);

        // word write slot 3, zero wait
        step(); addr_phase(32'h0300_0010, 1'b1, 3'd2, 4'b0011);
        mid();
        chk("w1_addr_ready", hreadyout, 1);
        step(); bus_idle(); hwdata = 32'hDEAD_BEEF; pready = 1'b1;
        mid();
        chk("w1_setup_psel", psel, 32'h8);
        chk("w1_setup_pen", penable, 0);
        chk("w1_setup_ready", hreadyout, 0);
        chk("w1_paddr", paddr, 32'h0300_0010);
        chk("w1_pstrb", pstrb, 4'hF);
        chk("w1_pwrite", pwrite, 1);
        chk("w1_pprot", pprot, 3'b011);
        step(); hwdata = 32'h0;
        mid();
        chk("w1_acc_pen", penable, 1);
        chk("w1_acc_psel", psel, 32'h8);
        chk("w1_pwdata", pwdata, 32'hDEAD_BEEF);
        chk("w1_acc_ready", hreadyout, 1);
        step();
        mid();
        chk("w1_done_psel", psel, 0);
        chk("w1_done_pen", penable, 0);

        // byte read slot 1, two wait states
        step(); addr_phase(32'h0100_0003, 1'b0, 3'd0, 4'b0000); pready = 1'b0;
        mid();
        step(); bus_idle();
        mid();
        chk("r1_setup_psel", psel, 32'h2);
        chk("r1_pstrb", pstrb, 0);
        chk("r1_pprot", pprot, 3'b110);
        step();
        mid();
        chk("r1_wait1_ready", hreadyout, 0);
        chk("r1_wait1_pen", penable, 1);
        step();
        mid();
        chk("r1_wait2_ready", hreadyout, 0);
        step(); pready = 1'b1; prdata = 32'h1234_5678;
        mid();
        chk("r1_ready", hreadyout, 1);
        chk("r1_hrdata", hrdata, 32'h1234_5678);
        step(); prdata = 32'h0;
        mid();
        chk("r1_idle_psel", psel, 0);

        // halfword write with slave error
        step(); addr_phase(32'h0200_0002, 1'b1, 3'd1, 4'b0001);
        mid();
        step(); bus_idle(); hwdata = 32'h0000_BEEF; pready = 1'b1; pslverr = 1'b1;
        mid();
        chk("e1_pstrb", pstrb, 4'hC);
        chk("e1_psel", psel, 32'h4);
        chk("e1_pprot", pprot, 3'b010);
        step();
        mid();
        chk("e1_acc_ready", hreadyout, 0);
        chk("e1_acc_hresp", hresp, 0);
        step(); pslverr = 1'b0;
        mid();
        chk("e1_err1_hresp", hresp, 1);
        chk("e1_err1_ready", hreadyout, 0);
        chk("e1_err1_psel", psel, 0);
        chk("e1_err1_pen", penable, 0);
        step();
        mid();
        chk("e1_err2_hresp", hresp, 1);
        chk("e1_err2_ready", hreadyout, 1);
        step();
        mid();
        chk("e1_idle_hresp", hresp, 0);

        // slot beyond NSLOTS
        step(); addr_phase(32'h0500_0000, 1'b0, 3'd2, 4'b0000);
        mid();
        step(); bus_idle();
        mid();
        chk("s5_err1_psel", psel, 0);
        chk("s5_err1_hresp", hresp, 1);
        chk("s5_err1_ready", hreadyout, 0);
        step();
        mid();
        chk("s5_err2_psel", psel, 0);
        chk("s5_err2_hresp", hresp, 1);
        chk("s5_err2_ready", hreadyout, 1);
        step();
        mid();
        chk("s5_idle_hresp", hresp, 0);

        // oversize transfer
        step(); addr_phase(32'h0000_0000, 1'b1, 3'd3, 4'b0000);
        mid();
        step(); bus_idle();
        mid();
        chk("sz3_hresp", hresp, 1);
        chk("sz3_psel", psel, 0);
        step(); step();

        // timeout: 8 ACCESS cycles then abort
        addr_phase(32'h0100_0000, 1'b0, 3'd2, 4'b0000); pready = 1'b0;
        mid();
        step(); bus_idle();
        mid();
        chk("to_setup_psel", psel, 32'h2);
        for (int i = 0; i < 8; i++) begin
            step();
            mid();
            chk($sformatf("to_acc%0d_pen", i), penable, 1);
            chk($sformatf("to_acc%0d_ready", i), hreadyout, 0);
        end
        step();
        mid();
        chk("to_err1_pen", penable, 0);
        chk("to_err1_psel", psel, 0);
        chk("to_err1_hresp", hresp, 1);
        chk("to_err1_ready", hreadyout, 0);
        step();
        mid();
        chk("to_err2_hresp", hresp, 1);
        chk("to_err2_ready", hreadyout, 1);
        step();

        // back-to-back writes, slot 1 then slot 2
        addr_phase(32'h0100_0001, 1'b1, 3'd0, 4'b0000); pready = 1'b1;
        mid();
        step(); addr_phase(32'h0200_0008, 1'b1, 3'd2, 4'b0000); hwdata = 32'h0000_00AA;
        mid();
        chk("bb1_psel", psel, 32'h2);
        chk("bb1_pstrb", pstrb, 4'b0010);
        step();
        mid();
        chk("bb1_ready", hreadyout, 1);
        chk("bb1_pwdata", pwdata, 32'h0000_00AA);
        step(); bus_idle(); hwdata = 32'h5566_7788;
        mid();
        chk("bb2_setup_psel", psel, 32'h4);
        chk("bb2_setup_pen", penable, 0);
        chk("bb2_paddr", paddr, 32'h0200_0008);
        chk("bb2_pstrb", pstrb, 4'hF);
        step();
        mid();
        chk("bb2_pwdata", pwdata, 32'h5566_7788);
        chk("bb2_ready", hreadyout, 1);
        step();
        mid();
        chk("bb2_idle_psel", psel, 0);

        // reset during ACCESS
        step(); addr_phase(32'h0300_0004, 1'b1, 3'd2, 4'b0001); pready = 1'b0;
        mid();
        step(); bus_idle(); hwdata = 32'hCAFE_F00D;
        mid();
        step();
        mid();
        chk("rs_acc_pen", penable, 1);
        chk("rs_acc_pwdata", pwdata, 32'hCAFE_F00D);
        step(); hresetn = 1'b0;
        mid();
        step();
        mid();
        chk("rs_psel", psel, 0);
        chk("rs_penable", penable, 0);
        chk("rs_paddr", paddr, 0);
        chk("rs_pwdata", pwdata, 0);
        chk("rs_pstrb", pstrb, 0);
        chk("rs_pprot", pprot, 0);
        chk("rs_pwrite", pwrite, 0);
        chk("rs_hreadyout", hreadyout, 1);
        chk("rs_hresp", hresp, 0);
        step(); hresetn = 1'b1;
        step();
        mid();
        chk("rs_after_psel", psel, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge_p.md
AHB_APB_BRIDGE_P -- requirements
Module: ahb_apb_bridge_p

Interface
REQ-001 SHALL provide parameter NSLOTS, default 16, number of APB slave selects (1..16).
REQ-002 SHALL provide parameter SLOT_LSB, default 24, lowest HADDR bit of the 4-bit slot index field.
REQ-003 SHALL provide parameter TIMEOUT, default 0, ACCESS cycles before abort; 0 disables the timeout.
REQ-004 SHALL use one clock, HCLK; reset is HRESETN, synchronous and active-low.
REQ-005 HCLK  in  1  clock, all logic on rising edge.
REQ-006 HRESETN  in  1  synchronous active-low reset.
REQ-007 HSEL, HWRITE, HREADYIN  in  1 each  AHB select, direction, previous-transfer-done.
REQ-008 HADDR  in  32; HWDATA  in  32; HTRANS  in  2; HSIZE  in  3; HPROT  in  4  AHB address/data/control.
REQ-009 HRDATA  out  32; HREADYOUT  out  1; HRESP  out  1  AHB response.
REQ-010 PSEL  out  NSLOTS  one-hot slave select.
REQ-011 PADDR  out  32; PWRITE  out  1; PENABLE  out  1; PWDATA  out  32; PSTRB  out  4; PPROT  out  3  APB request.
REQ-012 PRDATA  in  32; PREADY  in  1; PSLVERR  in  1  APB response.

Function
REQ-013 SHALL implement states IDLE, SETUP, ACCESS, ERR1, ERR2.
REQ-014 Accept condition: HSEL=1 & HREADYIN=1 & HTRANS[1]=1, sampled in IDLE, ERR2, or in ACCESS on a cycle with HREADYOUT=1.
REQ-015 On accept: latch HADDR, HWRITE, HSIZE, HPROT; slot = HADDR[SLOT_LSB+3:SLOT_LSB].
REQ-016 On accept, if slot >= NSLOTS or HSIZE > 2, SHALL go to ERR1 with no APB access; otherwise go to SETUP.
REQ-017 SETUP: PSEL[slot]=1 only, PENABLE=0; PWDATA = HWDATA, registered at the end of SETUP; timeout counter cleared; next state ACCESS.
REQ-018 ACCESS: PENABLE=1, PSEL held, PADDR/PWRITE/PWDATA/PSTRB/PPROT stable.
REQ-019 ACCESS with PREADY=1, PSLVERR=0: HREADYOUT=1 combinationally in the same cycle; PSEL/PENABLE drop next cycle; next state SETUP if a new transfer is accepted, else IDLE.
REQ-020 ACCESS with PREADY=1, PSLVERR=1: HREADYOUT=0; next state ERR1; PSEL/PENABLE drop.
REQ-021 ACCESS with PREADY=0: counter increments; if TIMEOUT>0 and counter reaches TIMEOUT-1 with PREADY=0, SHALL abort (drop PSEL/PENABLE) and go to ERR1.
REQ-022 ERR1: HRESP=1, HREADYOUT=0; next state ERR2. ERR2: HRESP=1, HREADYOUT=1; next state follows REQ-014/016, else IDLE.
REQ-023 IDLE: HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0.
REQ-024 PSTRB for writes: byte -> 1 << HADDR[1:0]; half -> 0011 if HADDR[1]=0, else 1100; word -> 1111. For reads: 0000.
REQ-025 PPROT = {~HPROT[0], 1, HPROT[1]}, latched at accept.
REQ-026 PADDR = latched HADDR, full 32 bits, unmodified.
REQ-027 HRDATA SHALL equal PRDATA combinationally.
REQ-028 Minimum transfer: 3 HCLK cycles (address, SETUP, ACCESS) with zero-wait APB.
REQ-029 HTRANS IDLE/BUSY (HTRANS[1]=0) SHALL be ignored, with HREADYOUT=1 and HRESP=0.

Reset
REQ-030 HRESETN=0 at a rising edge SHALL force, on the next cycle: state IDLE, HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, PPROT=0, counter=0.
REQ-031 Reset asserted mid-SETUP, ACCESS, or ERR SHALL abandon the transfer with no further APB or AHB response.

Verification
REQ-032 Word write 0x0300_0010 = 0xDEADBEEF, PREADY=1 -> PSEL=0x0008, PSTRB=1111, PWDATA=0xDEADBEEF, HREADYOUT high in the 3rd cycle.
REQ-033 Byte read 0x0100_0003, PRDATA=0x12345678, PREADY low 2 cycles -> PSTRB=0000, HRDATA=0x12345678 when HREADYOUT=1, 5 cycles total.
REQ-034 PSLVERR=1 on ACCESS -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1.
REQ-035 NSLOTS=4, access to 0x0500_0000 -> PSEL stays 0, two-cycle error response.
REQ-036 TIMEOUT=8, PREADY held 0 -> abort after 8 ACCESS cycles, then error response; back-to-back writes to slots 1 and 2 -> no IDLE gap between transfers.
REQ-037 HRESETN low during ACCESS -> all outputs at reset values next cycle.
